// File: rtl/qs_srt_pkg.sv
// qs_srt_pkg: shared types for the SRT micro-engine sequencer (state encoding, decoded ucode).
package qs_srt_pkg;
  localparam int PC_W_DEF = 8;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_AWAIT = 3'd3,
    S_EMIT  = 3'd4,
    S_ERROR = 3'd5
  } seq_state_t;
  typedef struct packed {
    logic                invalid_inst;
    logic                is_jump;
    logic                is_call;
    logic                is_ret;
    logic                is_await;
    logic                is_emit;
    logic [3:0]          cc;
    logic [PC_W_DEF-1:0] target;
  } ucode_t;
endpackage

// File: rtl/qs_srt_seq_ctrl_if.sv
// qs_srt_seq_ctrl_if: host/imem/issue/event/emit signals of the sequencer.
// master = sequencer side, slave = host + instruction RAM + execute stage side.
interface qs_srt_seq_ctrl_if
  import qs_srt_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) ();
  logic            start_vld;
  logic [PC_W-1:0] start_pc;
  logic            start_rdy;
  logic            kill;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  ucode_t          ucode;
  logic            cc_pass;
  logic [PC_W-1:0] blink;
  logic            issue_vld;
  logic            issue_rdy;
  logic [PC_W-1:0] link_pc;
  logic            evt_vld;
  logic            emit_vld;
  logic            emit_rdy;
  logic            busy;
  logic            err;
  modport master (
    input  start_vld, start_pc, kill, ucode, cc_pass, blink, issue_rdy, evt_vld, emit_rdy,
    output start_rdy, imem_en, imem_addr, issue_vld, link_pc, emit_vld, busy, err
  );
  modport slave (
    output start_vld, start_pc, kill, ucode, cc_pass, blink, issue_rdy, evt_vld, emit_rdy,
    input  start_rdy, imem_en, imem_addr, issue_vld, link_pc, emit_vld, busy, err
  );
endinterface

// File: rtl/qs_srt_seq_perf_cnt.sv
// qs_srt_seq_perf_cnt: saturating up-counter with synchronous clear.
// Ports: clk, arst_n (async active-low), i_clr, i_inc, o_cnt[W].
module qs_srt_seq_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/qs_srt_seq_ctrl.sv
// qs_srt_seq_ctrl: SRT micro-engine instruction sequencer (PC, imem read, issue gating, jump/call/ret, AWAIT/EMIT).
// Ports: clk, arst_n (async active-low), bus (qs_srt_seq_ctrl_if.master: start/kill, imem read,
//   ucode/cc_pass/blink, issue handshake + link_pc, evt_vld, emit handshake, busy, err).
// Optional QS_SRT_SEQ_PERF_EN adds perf_retired/perf_stall saturating counters (CNT_W bits).
module qs_srt_seq_ctrl
  import qs_srt_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
`ifdef QS_SRT_SEQ_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic arst_n,
  qs_srt_seq_ctrl_if.master bus
`ifdef QS_SRT_SEQ_PERF_EN
  , output logic [CNT_W-1:0] perf_retired
  , output logic [CNT_W-1:0] perf_stall
`endif
);
  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_FETCH = S_FETCH;
  localparam logic [2:0] ST_EXEC  = S_EXEC;
  localparam logic [2:0] ST_AWAIT = S_AWAIT;
  localparam logic [2:0] ST_EMIT  = S_EMIT;
  localparam logic [2:0] ST_ERROR = S_ERROR;
  logic [2:0]      r_state, w_nstate;
  logic [PC_W-1:0] r_pc, w_npc, w_pc_inc;
  logic            r_err, w_nerr;
  logic            w_taken;
  logic            w_unused;
  assign w_pc_inc = r_pc + 1'b1;
  assign w_taken  = bus.ucode.is_call | (bus.ucode.is_jump & bus.cc_pass);
  assign w_unused = ^bus.ucode.cc;
  always_comb begin
    w_nstate = r_state;
    w_npc    = r_pc;
    w_nerr   = r_err;
    case (r_state)
      ST_IDLE:
        if (bus.start_vld) begin
          w_nstate = ST_FETCH;
          w_npc    = bus.start_pc;
          w_nerr   = 1'b0;
        end
      ST_FETCH: w_nstate = ST_EXEC;
      ST_EXEC:
        if (bus.ucode.invalid_inst) begin
          w_nstate = ST_ERROR;
          w_nerr   = 1'b1;
        end else if (bus.issue_rdy) begin
          w_nstate = bus.ucode.is_await ? ST_AWAIT : bus.ucode.is_emit ? ST_EMIT : ST_FETCH;
          w_npc    = w_taken ? PC_W'(bus.ucode.target) : bus.ucode.is_ret ? bus.blink : w_pc_inc;
        end
      ST_AWAIT: w_nstate = bus.evt_vld ? ST_FETCH : ST_AWAIT;
      ST_EMIT:  w_nstate = bus.emit_rdy ? ST_FETCH : ST_EMIT;
      ST_ERROR: w_nstate = ST_ERROR;
      default:  w_nstate = ST_IDLE;
    endcase
    if (bus.kill) begin
      w_nstate = ST_IDLE;
      w_npc    = r_pc;
      w_nerr   = r_err;
    end
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      r_err   <= w_nerr;
    end
  // kill masks every request strobe combinationally so nothing leaves in the abort cycle
  assign bus.start_rdy = r_state == ST_IDLE;
  assign bus.imem_en   = r_state == ST_FETCH && !bus.kill;
  assign bus.imem_addr = bus.imem_en ? r_pc : '0;
  assign bus.issue_vld = r_state == ST_EXEC && !bus.ucode.invalid_inst && !bus.kill;
  assign bus.link_pc   = bus.issue_vld ? w_pc_inc : '0;
  assign bus.emit_vld  = r_state == ST_EMIT && !bus.kill;
  assign bus.busy      = r_state != ST_IDLE;
  assign bus.err       = r_err;
`ifdef QS_SRT_SEQ_PERF_EN
  logic w_start_acc, w_stall;
  assign w_start_acc = r_state == ST_IDLE && bus.start_vld && !bus.kill;
  assign w_stall     = (r_state == ST_EXEC && !bus.issue_rdy) || r_state == ST_AWAIT ||
                       (r_state == ST_EMIT && !bus.emit_rdy);
  qs_srt_seq_perf_cnt #(.W(CNT_W)) u_retired (
    .clk(clk), .arst_n(arst_n), .i_clr(w_start_acc),
    .i_inc(bus.issue_vld && bus.issue_rdy), .o_cnt(perf_retired)
  );
  qs_srt_seq_perf_cnt #(.W(CNT_W)) u_stall (
    .clk(clk), .arst_n(arst_n), .i_clr(w_start_acc),
    .i_inc(w_stall), .o_cnt(perf_stall)
  );
`endif
endmodule

// File: tb/tb_qs_srt_seq_ctrl.sv
// tb_qs_srt_seq_ctrl: directed self-checking bench for qs_srt_seq_ctrl.
module tb_qs_srt_seq_ctrl;
  import qs_srt_pkg::*;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  qs_srt_seq_ctrl_if #(.PC_W(8)) bus ();
`ifdef QS_SRT_SEQ_PERF_EN
  logic [31:0] perf_retired, perf_stall;
`endif
  qs_srt_seq_ctrl #(.PC_W(8)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
`ifdef QS_SRT_SEQ_PERF_EN
    , .perf_retired(perf_retired)
    , .perf_stall(perf_stall)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // f = {invalid, jump, call, ret, await, emit}
  function automatic ucode_t mk(input logic [5:0] f, input logic [7:0] t);
    ucode_t u;
    u = '0;
    {u.invalid_inst, u.is_jump, u.is_call, u.is_ret, u.is_await, u.is_emit} = f;
    u.target = t;
    return u;
  endfunction
  // Entered in FETCH: checks fetch address, presents u in EXEC, checks issue/link, advances past accept.
  task automatic step(input string tag, input logic [7:0] pc, input ucode_t u, input logic cc);
    chk({tag, "_en"}, 32'(bus.imem_en), 1);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(pc));
    tick;
    bus.ucode = u;
    bus.cc_pass = cc;
    #1;
    chk({tag, "_iv"}, 32'(bus.issue_vld), 1);
    chk({tag, "_lnk"}, 32'(bus.link_pc), 32'(8'(pc + 8'd1)));
    tick;
    bus.ucode = '0;
    bus.cc_pass = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start_vld = 0; bus.start_pc = '0; bus.kill = 0; bus.ucode = '0; bus.cc_pass = 0;
    bus.blink = '0; bus.issue_rdy = 0; bus.evt_vld = 0; bus.emit_rdy = 0;
    tick;
    tick;
    chk("rst_start_rdy", 32'(bus.start_rdy), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_imem_en", 32'(bus.imem_en), 0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 0);
    chk("rst_issue_vld", 32'(bus.issue_vld), 0);
    chk("rst_link_pc", 32'(bus.link_pc), 0);
    chk("rst_emit_vld", 32'(bus.emit_vld), 0);
    chk("rst_err", 32'(bus.err), 0);
    arst_n = 1'b1;
    tick;
    bus.issue_rdy = 1;
    bus.start_pc = 8'h10;
    bus.start_vld = 1;
    tick;
    bus.start_vld = 0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_rdy_low", 32'(bus.start_rdy), 0);
    step("nop0", 8'h10, '0, 0);
    step("nop1", 8'h11, '0, 0);
    step("nop2", 8'h12, '0, 0);
`ifdef QS_SRT_SEQ_PERF_EN
    chk("perf_retired3", perf_retired, 3);
    chk("perf_stall0", perf_stall, 0);
`endif
    step("jcc_nt", 8'h13, mk(6'b010000, 8'h40), 0);
    step("jcc_t", 8'h14, mk(6'b010000, 8'h40), 1);
    step("jmp05", 8'h40, mk(6'b010000, 8'h05), 1);
    step("call", 8'h05, mk(6'b001000, 8'h20), 0);
    bus.blink = 8'h06;
    step("ret", 8'h20, mk(6'b000100, 8'h00), 0);
    step("jmp08", 8'h06, mk(6'b010000, 8'h08), 1);
    bus.evt_vld = 1;
    step("await", 8'h08, mk(6'b000010, 8'h00), 0);
    bus.evt_vld = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("await_hold", 32'({bus.busy, bus.imem_en}), 32'b10);
      tick;
    end
    bus.evt_vld = 1;
    tick;
    bus.evt_vld = 0;
    bus.emit_rdy = 0;
    step("emit", 8'h09, mk(6'b000001, 8'h00), 0);
    for (int i = 0; i < 3; i++) begin
      chk("emit_hold", 32'(bus.emit_vld), 1);
      tick;
    end
    bus.emit_rdy = 1;
    #1;
    chk("emit_last", 32'(bus.emit_vld), 1);
    tick;
    bus.emit_rdy = 0;
    chk("emit_done", 32'(bus.emit_vld), 0);
`ifdef QS_SRT_SEQ_PERF_EN
    chk("perf_retired11", perf_retired, 11);
    chk("perf_stall9", perf_stall, 9);
`endif
    chk("inv_addr", 32'(bus.imem_addr), 32'h0A);
    tick;
    bus.ucode = mk(6'b100000, 8'h00);
    bus.issue_rdy = 0;
    #1;
    chk("inv_iv", 32'(bus.issue_vld), 0);
    tick;
    bus.ucode = '0;
    chk("err_set", 32'(bus.err), 1);
    chk("err_busy", 32'(bus.busy), 1);
    tick;
    tick;
    chk("err_sticky", 32'(bus.err), 1);
    chk("err_no_fetch", 32'(bus.imem_en), 0);
    bus.kill = 1;
    tick;
    bus.kill = 0;
    chk("kill_err_idle", 32'(bus.start_rdy), 1);
    chk("kill_err_busy", 32'(bus.busy), 0);
    chk("kill_err_kept", 32'(bus.err), 1);
    bus.issue_rdy = 1;
    bus.start_pc = 8'hFF;
    bus.start_vld = 1;
    tick;
    bus.start_vld = 0;
    chk("start_err_clr", 32'(bus.err), 0);
    step("wrap", 8'hFF, '0, 0);
    chk("wrap_addr", 32'(bus.imem_addr), 0);
    tick;
    bus.issue_rdy = 0;
    #1;
    chk("stall_iv", 32'(bus.issue_vld), 1);
    tick;
    chk("stall_hold_iv", 32'(bus.issue_vld), 1);
    bus.kill = 1;
    #1;
    chk("kill_mask_iv", 32'(bus.issue_vld), 0);
    tick;
    bus.kill = 0;
    chk("kill_idle", 32'(bus.start_rdy), 1);
    chk("kill_busy", 32'(bus.busy), 0);
    bus.issue_rdy = 1;
    bus.kill = 1;
    bus.start_pc = 8'h30;
    bus.start_vld = 1;
    tick;
    chk("kill_start_idle", 32'(bus.busy), 0);
    bus.kill = 0;
    tick;
    bus.start_vld = 0;
    chk("restart_addr", 32'(bus.imem_addr), 32'h30);
    tick;
    bus.start_pc = 8'h77;
    bus.start_vld = 1;
    tick;
    bus.start_vld = 0;
    chk("busy_start_ignored", 32'(bus.imem_addr), 32'h31);
    tick;
    arst_n = 0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_start_rdy", 32'(bus.start_rdy), 1);
    chk("arst_iv", 32'(bus.issue_vld), 0);
    chk("arst_err", 32'(bus.err), 0);
`ifdef QS_SRT_SEQ_PERF_EN
    chk("arst_perf", perf_retired, 0);
`endif
    tick;
    arst_n = 1;
    tick;
    chk("post_rst_idle", 32'(bus.start_rdy), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
